// File: rtl/uart_audio_frame_scheduler_pkg.sv
// Shared types and constants for the UART audio frame scheduler.
// UART_AUDIO_CHECKSUM_EN selects the 6-byte frame with a trailing XOR checksum.
package uart_audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_IDLE,
    DONE
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned IDX_W             = 3;

  localparam logic [IDX_W-1:0] LAST_IDX_PLAIN = 3'd4;
  localparam logic [IDX_W-1:0] LAST_IDX_CSUM  = 3'd5;

`ifdef UART_AUDIO_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = LAST_IDX_CSUM;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = LAST_IDX_PLAIN;
`endif

  function automatic logic [7:0] frame_byte(input logic [7:0]       sync,
                                            input logic [15:0]      l,
                                            input logic [15:0]      r,
                                            input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = l[15:8];
      3'd2:    b = l[7:0];
      3'd3:    b = r[15:8];
      3'd4:    b = r[7:0];
`ifdef UART_AUDIO_CHECKSUM_EN
      3'd5:    b = l[15:8] ^ l[7:0] ^ r[15:8] ^ r[7:0];
`endif
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_audio_frame_scheduler_if.sv
// Sample-source and UART-transmitter signals of the audio frame scheduler.
interface uart_audio_frame_scheduler_if;
  logic [15:0] L_Sample;
  logic        L_Valid;
  logic [15:0] R_Sample;
  logic        R_Valid;
  logic        Pair_Ready;
  logic        Tx_Busy;
  logic [7:0]  Tx_Data;
  logic        Tx_Load;
  logic        Tx_Start;
  logic        Frame_Done;
  logic [15:0] Frame_Count;
  logic        Tx_Fault;

  modport slave (
    input  L_Sample, L_Valid, R_Sample, R_Valid, Tx_Busy,
    output Pair_Ready, Tx_Data, Tx_Load, Tx_Start, Frame_Done, Frame_Count, Tx_Fault
  );

  modport master (
    output L_Sample, L_Valid, R_Sample, R_Valid, Tx_Busy,
    input  Pair_Ready, Tx_Data, Tx_Load, Tx_Start, Frame_Done, Frame_Count, Tx_Fault
  );
endinterface

// File: rtl/uart_audio_frame_scheduler_byte_launcher.sv
// One-byte UART handshake: load pulse, start pulse, wait for busy (with timeout), wait for idle.
module uart_byte_launcher
  import uart_audio_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic byte_go,
  input  logic tx_busy,
  output logic tx_load,
  output logic tx_start,
  output logic byte_done,
  output logic byte_fault
);

  localparam logic [3:0] TIMEOUT = 4'(BUSY_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_q, load_d;
  logic       start_q, start_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_done  = 1'b0;
    byte_fault = 1'b0;
    case (state_q)
      IDLE:      if (byte_go) state_d = LOAD;
      LOAD:      state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      // Busy wins over a timeout expiring in the same cycle.
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT) begin
            byte_fault = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      // byte_go here chains straight into the next byte without an IDLE cycle.
      WAIT_IDLE: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          state_d   = byte_go ? LOAD : IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
    load_d  = (state_d == LOAD);
    start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      start_q <= start_d;
    end
  end

  assign tx_load  = load_q;
  assign tx_start = start_q;

endmodule

// File: rtl/uart_audio_frame_scheduler.sv
// Captures an L/R sample pair and sends it as SYNC,L_hi,L_lo,R_hi,R_lo through the UART TX.
// UART_AUDIO_CHECKSUM_EN appends an XOR checksum byte over the four sample bytes.
module uart_audio_frame_scheduler
  import uart_audio_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input logic                          CLOCK_50,
  input logic                          Reset,
  uart_audio_frame_scheduler_if.slave  bus
);

  logic [15:0]      l_q, l_d, r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             fault_q, fault_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic pair_ready, capture, byte_go, byte_done, byte_fault;

  uart_byte_launcher #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) u_launcher (
    .clk        (CLOCK_50),
    .rst        (Reset),
    .byte_go    (byte_go),
    .tx_busy    (bus.Tx_Busy),
    .tx_load    (bus.Tx_Load),
    .tx_start   (bus.Tx_Start),
    .byte_done  (byte_done),
    .byte_fault (byte_fault)
  );

  // Not active and not in the Frame_Done cycle is exactly the launcher's IDLE.
  assign pair_ready = ~active_q & ~done_q;
  assign capture    = pair_ready & bus.L_Valid & bus.R_Valid;
  assign byte_go    = capture | (byte_done & (idx_q != LAST_IDX));

  always_comb begin
    l_d           = l_q;
    r_d           = r_q;
    idx_d         = idx_q;
    active_d      = active_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    fault_d       = fault_q | byte_fault;
    if (capture) begin
      l_d      = bus.L_Sample;
      r_d      = bus.R_Sample;
      idx_d    = '0;
      active_d = 1'b1;
    end
    if (byte_done) begin
      if (idx_q == LAST_IDX) begin
        active_d      = 1'b0;
        done_d        = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    if (byte_fault) active_d = 1'b0;
    tx_data_d = byte_go ? frame_byte(SYNC_BYTE, l_d, r_d, idx_d) : tx_data_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      l_q           <= '0;
      r_q           <= '0;
      idx_q         <= '0;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
      fault_q       <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      l_q           <= l_d;
      r_q           <= r_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
      fault_q       <= fault_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign bus.Pair_Ready  = pair_ready;
  assign bus.Tx_Data     = tx_data_q;
  assign bus.Frame_Done  = done_q;
  assign bus.Frame_Count = frame_count_q;
  assign bus.Tx_Fault    = fault_q;

endmodule

// File: tb/tb_uart_audio_frame_scheduler.sv
// Randomized and directed bench for uart_audio_frame_scheduler with a UART TX model and byte scoreboard.
module tb_uart_audio_frame_scheduler;

  logic CLOCK_50 = 1'b0;
  logic Reset    = 1'b1;

  uart_audio_frame_scheduler_if bus();

  uart_audio_frame_scheduler #(
    .SYNC_BYTE    (8'hA5),
    .BUSY_TIMEOUT (15)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_loads = 0;
  int          done_pulses = 0;
  int          busy_len = 1085;
  bit          tx_ok = 1'b1;
  logic [15:0] mdl_count = '0;
  logic [7:0]  last_load = '0;
  logic [7:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Transmitter model: busy one cycle after the start pulse, for busy_len cycles.
  initial begin : tx_model
    int  rem;
    bit  launch;
    rem    = 0;
    launch = 1'b0;
    bus.Tx_Busy = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (Reset) begin
        rem = 0; launch = 1'b0; bus.Tx_Busy = 1'b0;
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) bus.Tx_Busy = 1'b0;
        end
        if (launch) begin
          launch = 1'b0;
          bus.Tx_Busy = 1'b1;
          rem = busy_len;
        end
        if (bus.Tx_Start && tx_ok) launch = 1'b1;
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (!Reset) begin
      if (bus.Tx_Load) begin
        n_loads++;
        check_eq("load_while_busy", bus.Tx_Busy, 0);
        if (exp_q.size() == 0) check_eq("unexpected_load", 1, 0);
        else check_eq("tx_byte", bus.Tx_Data, exp_q.pop_front());
        last_load = bus.Tx_Data;
      end
      if (bus.Tx_Start) begin
        check_eq("load_start_overlap", bus.Tx_Load, 0);
        check_eq("start_data_held", bus.Tx_Data, last_load);
      end
      if (bus.Frame_Done) done_pulses++;
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back(8'hA5);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
`ifdef UART_AUDIO_CHECKSUM_EN
    exp_q.push_back(l[15:8] ^ l[7:0] ^ r[15:8] ^ r[7:0]);
`endif
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.L_Valid = 1'b0;
    bus.R_Valid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    exp_q.delete();
    mdl_count = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_tx_data"},     bus.Tx_Data, 0);
    check_eq({pfx, "_tx_load"},     bus.Tx_Load, 0);
    check_eq({pfx, "_tx_start"},    bus.Tx_Start, 0);
    check_eq({pfx, "_frame_done"},  bus.Frame_Done, 0);
    check_eq({pfx, "_frame_count"}, bus.Frame_Count, 0);
    check_eq({pfx, "_tx_fault"},    bus.Tx_Fault, 0);
    check_eq({pfx, "_pair_ready"},  bus.Pair_Ready, 1);
  endtask

  task automatic offer_pair(input logic [15:0] l, input logic [15:0] r);
    bit rdy;
    rdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.Pair_Ready) begin rdy = 1'b1; break; end
      tick();
    end
    check_eq("pair_ready_wait", rdy, 1);
    bus.L_Sample = l;
    bus.R_Sample = r;
    bus.L_Valid  = 1'b1;
    bus.R_Valid  = 1'b1;
    push_frame(l, r);
    tick();
    bus.L_Valid  = 1'b0;
    bus.R_Valid  = 1'b0;
    bus.L_Sample = 16'($urandom);
    bus.R_Sample = 16'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 7 * (busy_len + 30); i++) begin
      tick();
      if (bus.Frame_Done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    offer_pair(l, r);
    wait_done(ok);
    mdl_count = mdl_count + 16'd1;
    check_eq("frame_done_seen", ok, 1);
    check_eq("frame_count", bus.Frame_Count, mdl_count);
    check_eq("bytes_left_at_done", exp_q.size(), 0);
    tick();
    check_eq("done_one_cycle", bus.Frame_Done, 0);
    check_eq("idle_after_done", bus.Pair_Ready, 1);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s, d, loads0, done0;
    bit seen;
    bus.L_Sample = '0;
    bus.R_Sample = '0;
    bus.L_Valid  = 1'b0;
    bus.R_Valid  = 1'b0;
    do_reset();
    check_reset_outputs("reset");

    // Basic frame with the reference samples.
    busy_len = 1085;
    done0 = done_pulses;
    send_frame(16'h1234, 16'hABCD);
    check_eq("single_done_pulse", done_pulses - done0, 1);

    // One valid alone must not start a frame.
    loads0 = n_loads;
    bus.L_Sample = 16'h5A5A;
    bus.L_Valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("ready_l_only", bus.Pair_Ready, 1);
    end
    check_eq("no_load_l_only", n_loads - loads0, 0);
    send_frame(16'h5A5A, 16'h0F0F);

    // Transmitter never goes busy: fault after the timeout.
    tx_ok = 1'b0;
    loads0 = n_loads;
    offer_pair(16'h1111, 16'h2222);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.Tx_Start) begin seen = 1'b1; break; end
      tick();
    end
    check_eq("start_seen", seen, 1);
    s = cyc;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Tx_Fault) begin seen = 1'b1; break; end
    end
    d = cyc - s;
    check_eq("fault_seen", seen, 1);
    check_eq("fault_latency", d, 16);
    check_eq("fault_idle", bus.Pair_Ready, 1);
    check_eq("fault_count_same", bus.Frame_Count, mdl_count);
    check_eq("fault_one_load", n_loads - loads0, 1);
    exp_q.delete();
    tx_ok = 1'b1;
    busy_len = 12;
    send_frame(16'h3333, 16'h4444);
    check_eq("fault_sticky", bus.Tx_Fault, 1);

    // Reset in the middle of the third byte.
    do_reset();
    busy_len = 1085;
    offer_pair(16'h1234, 16'hABCD);
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (n_loads - loads0 >= 0 && exp_q.size() <= 2) begin seen = 1'b1; break; end
      tick();
    end
    check_eq("third_byte_reached", seen, 1);
    repeat (100) tick();
    Reset = 1'b1;
    tick();
    check_reset_outputs("midframe_reset");
    Reset = 1'b0;
    exp_q.delete();
    mdl_count = '0;
    busy_len = 20;
    send_frame(16'hCAFE, 16'hBEEF);

    // Frame counter wrap.
    force dut.frame_count_q = 16'hFFFE;
    tick();
    release dut.frame_count_q;
    tick();
    check_eq("count_preset", bus.Frame_Count, 16'hFFFE);
    mdl_count = 16'hFFFE;
    busy_len = 1085;
    send_frame(16'h8000, 16'h7FFF);
    send_frame(16'hFFFF, 16'h0001);
    check_eq("count_wrapped", bus.Frame_Count, 16'h0000);

    // Randomized frames, gaps, lone valids and short transmitter busy times.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] l, r;
      l = 16'($urandom);
      r = 16'($urandom);
      busy_len = $urandom_range(1, 60);
      if ($urandom_range(0, 1) == 1) begin
        bus.R_Sample = r;
        bus.R_Valid  = 1'b1;
        repeat ($urandom_range(1, 6)) tick();
      end
      repeat ($urandom_range(0, 4)) tick();
      send_frame(l, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
